// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one single-port memory between fetch and data.
// Alternating priority, per-transaction timeout watchdog and a halt handshake.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              halted,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic [7:0]        timer;
    logic [7:0]        timer_inc;
    logic              last_dm;
    logic              if_pend, dm_pend;
    logic              grant_if, grant_dm;
    logic              busy, ack_hit, to_hit;

    // A requester whose ready is high is finishing; its held req is not new.
    assign if_pend   = if_req & ~if_ready;
    assign dm_pend   = dm_req & ~dm_ready;
    assign busy      = (state == IF_BUSY) | (state == DM_BUSY);
    assign timer_inc = timer + 8'd1;
    assign ack_hit   = busy & mem_ack;
    assign to_hit    = busy & ~mem_ack & (timer_inc == TO_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        case (state)
            IDLE: begin
                if (hlt) begin
                    state_nx = HALT;
                end else if (dm_pend && (!if_pend || !last_dm)) begin
                    state_nx = DM_BUSY;
                    grant_dm = 1'b1;
                end else if (if_pend) begin
                    state_nx = IF_BUSY;
                    grant_if = 1'b1;
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (ack_hit || to_hit) state_nx = IDLE;
            end
            HALT: begin
                if (!hlt) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            timer    <= '0;
            last_dm  <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (grant_if || grant_dm) begin
                addr_q  <= grant_dm ? dm_addr : if_addr;
                wdata_q <= grant_dm ? dm_wdata : '0;
                we_q    <= grant_dm & dm_we;
                timer   <= '0;
                last_dm <= grant_dm;
            end else if (busy && !mem_ack) begin
                timer <= timer_inc;
            end
            // Timeout completes the owner with all-ones so it never hangs.
            if (ack_hit || to_hit) begin
                if (state == IF_BUSY) begin
                    if_ready <= 1'b1;
                    if_rdata <= ack_hit ? mem_rdata : '1;
                end else begin
                    dm_ready <= 1'b1;
                    if (to_hit)     dm_rdata <= '1;
                    else if (!we_q) dm_rdata <= mem_rdata;
                end
                if (to_hit) err <= 1'b1;
            end
        end
    end

    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign halted    = (state == HALT);
    assign stall     = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: behavioural memory, grant log,
// per-port expected-data queues checked by a negedge monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hlt = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ready;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] if_q[$];
    logic [15:0] dm_q[$];
    logic [32:0] grants[$];
    logic [15:0] mem_arr[logic [15:0]];

    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic        spur = 1'b0;
    int          busy_cnt = 0;
    int          last_len = 0;
    logic        prev_en = 1'b0;
    logic [32:0] snap = '0;

    mem_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .hlt      (hlt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall    (stall),
        .halted   (halted),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return 16'hDEAD;
    endfunction

    // Memory model: ack after ack_delay busy cycles, logs every grant.
    always @(negedge clk) begin
        if (!rst) begin
            mem_ack  = 1'b0;
            busy_cnt = 0;
            prev_en  = 1'b0;
        end else begin
            if (mem_en) begin
                if (!prev_en) begin
                    busy_cnt = 0;
                    snap = {mem_we, mem_addr, mem_wdata};
                    grants.push_back(snap);
                end else begin
                    chk("mem_cmd_stable", 48'({mem_we, mem_addr, mem_wdata}),
                        48'(snap));
                end
                busy_cnt++;
                last_len = busy_cnt;
                if (ack_en && busy_cnt > ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) mem_arr[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_read(mem_addr);
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack   = spur;
                mem_rdata = spur ? 16'hBAD0 : 16'h0000;
            end
            prev_en = mem_en;
        end
    end

    // Monitor: every ready pulse must match the next expected response.
    always @(negedge clk) begin
        if (rst) begin
            if (if_ready) begin
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_unexpected_ready: rdata %0h", if_rdata);
                end else begin
                    chk("if_rdata", 48'(if_rdata), 48'(if_q.pop_front()));
                end
            end
            if (dm_ready) begin
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_unexpected_ready: rdata %0h", dm_rdata);
                end else begin
                    chk("dm_rdata", 48'(dm_rdata), 48'(dm_q.pop_front()));
                end
            end
        end
    end

    task automatic do_fetch(input logic [15:0] a, input logic [15:0] exp,
                            output int lat);
        if_q.push_back(exp);
        if_req  = 1'b1;
        if_addr = a;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!if_ready && lat < 60);
        if (!if_ready) begin
            checks++; errors++;
            $display("FAIL fetch_wait: no if_ready after %0d cycles, need 1", lat);
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic do_dm(input logic we, input logic [15:0] a,
                         input logic [15:0] wd, input logic [15:0] exp);
        int n;
        dm_q.push_back(exp);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dm_ready && n < 60);
        if (!dm_ready) begin
            checks++; errors++;
            $display("FAIL dm_wait: no dm_ready after %0d cycles, need 1", n);
        end
        @(negedge clk);
        dm_req = 1'b0;
        dm_we  = 1'b0;
    endtask

    initial begin
        int lat, l1, l2, base;
        mem_arr[16'h0010] = 16'hA5A5;
        mem_arr[16'h0100] = 16'h1111;
        mem_arr[16'h0102] = 16'h1313;
        mem_arr[16'h0104] = 16'h1515;
        mem_arr[16'h0200] = 16'h2222;
        mem_arr[16'h0202] = 16'h2424;
        mem_arr[16'h0204] = 16'h2626;
        mem_arr[16'h0206] = 16'h2828;
        mem_arr[16'h0500] = 16'h5050;
        mem_arr[16'h0502] = 16'h5252;
        mem_arr[16'h0600] = 16'h6060;

        repeat (2) @(negedge clk);
        chk("rst_outputs", 48'({if_ready, dm_ready, mem_en, mem_we, halted,
                                err, stall}), 48'd0);
        chk("rst_rdata", 48'({if_rdata, dm_rdata}), 48'd0);
        chk("rst_mem_addr", 48'(mem_addr), 48'd0);
        rst = 1'b1;
        @(negedge clk);

        // Lone fetch: minimum latency and no re-grant in the ready cycle.
        do_fetch(16'h0010, 16'hA5A5, lat);
        chk("fetch_latency", 48'(lat), 48'd2);
        repeat (2) @(negedge clk);
        chk("fetch_grant_cnt", 48'(grants.size()), 48'd1);
        chk("fetch_grant", 48'(grants[0][32:16]), 48'({1'b0, 16'h0010}));

        // Concurrent streams: data first, then alternate.
        base = grants.size();
        fork
            begin
                do_dm(1'b0, 16'h0200, 16'h0000, 16'h2222);
                do_dm(1'b0, 16'h0202, 16'h0000, 16'h2424);
            end
            begin
                do_fetch(16'h0100, 16'h1111, l1);
                do_fetch(16'h0102, 16'h1313, l2);
            end
        join
        chk("alt_g0", 48'(grants[base][32:16]), 48'({1'b0, 16'h0200}));
        chk("alt_g1", 48'(grants[base+1][32:16]), 48'({1'b0, 16'h0100}));
        chk("alt_g2", 48'(grants[base+2][32:16]), 48'({1'b0, 16'h0202}));
        chk("alt_g3", 48'(grants[base+3][32:16]), 48'({1'b0, 16'h0102}));

        // After a data grant, a simultaneous pair goes to fetch first.
        do_dm(1'b0, 16'h0204, 16'h0000, 16'h2626);
        base = grants.size();
        fork
            do_fetch(16'h0104, 16'h1515, l1);
            do_dm(1'b0, 16'h0206, 16'h0000, 16'h2828);
        join
        chk("alt_if_first", 48'(grants[base][32:16]), 48'({1'b0, 16'h0104}));
        chk("alt_dm_next", 48'(grants[base+1][32:16]), 48'({1'b0, 16'h0206}));

        // Store with slow ack: command held, dm_rdata untouched.
        ack_delay = 2;
        base = grants.size();
        do_dm(1'b1, 16'h0300, 16'h1234, 16'h2828);
        chk("store_cmd", 48'(grants[base]), 48'({1'b1, 16'h0300, 16'h1234}));
        chk("store_len", 48'(last_len), 48'd3);
        chk("store_mem", 48'(mem_read(16'h0300)), 48'h1234);
        ack_delay = 0;
        do_dm(1'b0, 16'h0300, 16'h0000, 16'h1234);

        // Ack while idle does nothing.
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_idle", 48'({mem_en, err, if_ready, dm_ready}), 48'd0);

        // Ack on the timeout cycle: ack wins.
        ack_delay = 3;
        do_fetch(16'h0600, 16'h6060, lat);
        chk("ack_at_to_err", 48'(err), 48'd0);
        chk("ack_at_to_len", 48'(last_len), 48'd4);

        // No ack: timeout after 4 busy cycles.
        ack_en = 1'b0;
        do_fetch(16'h0400, 16'hFFFF, lat);
        chk("to_len", 48'(last_len), 48'd4);
        chk("to_err", 48'(err), 48'd1);
        ack_en = 1'b1;
        ack_delay = 0;
        do_dm(1'b0, 16'h0200, 16'h0000, 16'h2222);
        chk("err_sticky", 48'(err), 48'd1);

        // Halt mid-fetch: fetch completes, then halt holds off grants.
        ack_delay = 2;
        fork
            do_fetch(16'h0500, 16'h5050, lat);
            begin
                repeat (2) @(negedge clk);
                hlt = 1'b1;
            end
        join
        chk("halt_state", 48'({halted, mem_en}), 48'({1'b1, 1'b0}));
        base = grants.size();
        fork
            do_fetch(16'h0502, 16'h5252, lat);
            begin
                repeat (3) @(negedge clk);
                chk("halt_hold", 48'({halted, mem_en, stall}), 48'(3'b101));
                chk("halt_no_grant", 48'(grants.size()), 48'(base));
                hlt = 1'b0;
            end
        join
        chk("halt_resume", 48'(grants[base][32:16]), 48'({1'b0, 16'h0502}));

        // Reset mid-transaction.
        ack_en  = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0700;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 48'(mem_en), 48'd1);
        #2 rst = 1'b0;
        if_req = 1'b0;
        #1;
        chk("rst_mid_ctl", 48'({mem_en, mem_we, if_ready, dm_ready, halted,
                                err, stall}), 48'd0);
        chk("rst_mid_data", 48'({if_rdata, dm_rdata, mem_addr}), 48'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ready", 48'({if_ready, dm_ready}), 48'd0);
        end
        rst    = 1'b1;
        ack_en = 1'b1;
        ack_delay = 0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 48'({mem_en, if_ready}), 48'd0);
        do_fetch(16'h0010, 16'hA5A5, lat);
        chk("post_rst_lat", 48'(lat), 48'd2);

        repeat (3) @(negedge clk);
        chk("if_q_drained", 48'(if_q.size()), 48'd0);
        chk("dm_q_drained", 48'(dm_q.size()), 48'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum BUSY cycles without ack (8-bit count).
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port hlt  in  1  halt request.
REQ-007 SHALL have port if_req  in  1  fetch request, held until if_ready.
REQ-008 SHALL have port if_addr  in  ADDR_W  fetch address.
REQ-009 SHALL have port if_rdata  out  DATA_W  fetched instruction, registered.
REQ-010 SHALL have port if_ready  out  1  one-cycle fetch completion pulse.
REQ-011 SHALL have port dm_req  in  1  data request, held until dm_ready.
REQ-012 SHALL have port dm_we  in  1  data write enable (1 = store).
REQ-013 SHALL have port dm_addr  in  ADDR_W  data address.
REQ-014 SHALL have port dm_wdata  in  DATA_W  store data.
REQ-015 SHALL have port dm_rdata  out  DATA_W  load data, registered.
REQ-016 SHALL have port dm_ready  out  1  one-cycle data completion pulse.
REQ-017 SHALL have ports mem_en/mem_we (out 1), mem_addr (out ADDR_W), mem_wdata (out DATA_W): shared single-port memory command.
REQ-018 SHALL have ports mem_rdata (in DATA_W) and mem_ack (in 1): memory response.
REQ-019 SHALL have port stall  out  1  pipeline freeze.
REQ-020 SHALL have ports halted (out 1, halt acknowledged) and err (out 1, sticky timeout flag).

Function
REQ-021 SHALL implement states IDLE, IF_BUSY, DM_BUSY, HALT.
REQ-022 In IDLE: hlt=1 -> HALT; else exactly one pending request -> its BUSY state; both pending -> alternate, i.e. data wins unless the previous grant was data, then fetch wins.
REQ-023 On grant edge SHALL latch address, we (0 for fetch), wdata; mem_en=1 and mem_addr/mem_we/mem_wdata driven from latches, stable for entire BUSY.
REQ-024 In BUSY with mem_ack=1 SHALL, on that edge: load owner's rdata from mem_rdata (loads/fetches only; stores leave dm_rdata unchanged), set owner's ready for exactly the next cycle, drop mem_en, go to IDLE.
REQ-025 Minimum latency: req seen in IDLE cycle N -> mem_en cycle N+1 -> ack N+1 -> ready N+2.
REQ-026 During the cycle a requester's ready is high its req SHALL be ignored (no re-grant of completed request).
REQ-027 8-bit timer SHALL clear on grant and increment each BUSY cycle without ack; at count TIMEOUT: rdata all-ones, ready pulsed, err set, mem_en dropped, -> IDLE.
REQ-028 mem_ack and timeout on same cycle: ack wins, err unchanged.
REQ-029 mem_ack outside BUSY SHALL be ignored.
REQ-030 hlt during BUSY SHALL NOT abort; transaction completes, then HALT from IDLE.
REQ-031 HALT: no grants, mem_en=0, halted=1; hlt=0 -> IDLE next edge.
REQ-032 stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-033 err SHALL clear only on reset.

Reset
REQ-034 rst=0 SHALL asynchronously force IDLE, all outputs and rdata/latches/timer 0, err=0, alternation to data-first; in-flight transaction abandoned with no ready pulse.

Verification
REQ-035 Fetch only, if_addr=16'h0010, ack one cycle after mem_en, mem_rdata=16'hA5A5 -> mem_addr=16'h0010, if_ready pulse at N+2, if_rdata=16'hA5A5.
REQ-036 if_req and dm_req (load 16'h0200) same cycle, back-to-back -> data granted first, fetch next, then data again; no re-grant during ready cycles.
REQ-037 Store dm_addr=16'h0300, dm_wdata=16'h1234 -> mem_we=1, mem_wdata=16'h1234 held until ack; dm_rdata unchanged.
REQ-038 No ack, TIMEOUT=4 -> after 4 BUSY cycles ready pulses, rdata=16'hFFFF, err=1, stays 1 until reset.
REQ-039 hlt asserted mid-fetch -> fetch completes, then halted=1, mem_en=0; hlt=0 -> grants resume.
REQ-040 rst=0 mid-transaction -> immediate IDLE, all outputs 0, no ready pulse.
